cdb_arbiter: RTL
================

# cdb_arbiter

Common-data-bus arbiter that shares the single result-broadcast bus between the writeback sources: the reservation-station ALU, the load/store buffer, and a spare source. Each source pushes into its own small writeback FIFO. A round-robin scheduler pops one entry per cycle onto the registered broadcast bus. The bus is consumed by the reservation stations, the LSB and the ROB for dependency wake-up and commit marking.

## Interface
- NUM_SRC, default 3: number of writeback sources. Fixed order: 0 = ALU, 1 = LSB, 2 = spare.
- FIFO_DEPTH, default 4: entries per source FIFO; power of two, ≥2.
- ROB_W, default `ROB_WIDTH: ROB index width.

Ports:
- clk_in  in  1  system clock; the single clock.
- rst_in  in  1  reset, asynchronous, active-high.
- rdy_in  in  1  global ready; when low, all state is frozen.
- clear  in  1  pipeline flush (branch mispredict); acted on only when rdy_in = 1.
- src_valid  in  NUM_SRC  per-source push strobe.
- src_rob_id  in  NUM_SRC*ROB_W  packed ROB ids; source i occupies bits [i*ROB_W +: ROB_W].
- src_value  in  NUM_SRC*32  packed result values; source i occupies bits [i*32 +: 32].
- src_full  out  NUM_SRC  per-source FIFO full.
- cdb_valid  out  1  broadcast valid.
- cdb_rob_id  out  ROB_W  broadcast ROB id.
- cdb_value  out  32  broadcast value.
- cdb_src  out  $clog2(NUM_SRC)  index of the granted source, for debug and perf counters.

## Operation
- Push: at a clock edge with rdy_in=1, clear=0, src_valid[i]=1 and src_full[i]=0, write {rob_id, value} into FIFO i.
  - A push while src_full[i]=1 is discarded.
  - A source must not push while full.
  - src_full is derived from the registered count. A pop and a push in the same cycle on a full FIFO still rejects the push.
- Requests: req[i] = FIFO i non-empty.
- Arbitration is round-robin.
  - Pointer last_g holds the last granted index.
  - Priority order is last_g+1, last_g+2, …, wrapping modulo NUM_SRC.
  - The first source with req[i]=1 is granted.
  - last_g updates to the grant only when a grant occurs.
- Grant: pop the head of FIFO g. Register cdb_valid=1, cdb_rob_id and cdb_value from the head, and cdb_src=g.
- No grant (all FIFOs empty): cdb_valid is registered to 0. cdb_rob_id, cdb_value and cdb_src hold their previous values.
- Throughput: exactly one broadcast per cycle while any FIFO is non-empty. The bus never idles while a request is pending.
- clear (with rdy_in=1), at that edge:
  - all FIFOs are emptied (read and write pointers and counts return to 0);
  - same-cycle pushes are discarded;
  - cdb_valid is set to 0;
  - last_g is set to NUM_SRC-1.
- rdy_in=0: no push, no pop, no pointer update. All outputs hold, including cdb_valid.
- Reset (asynchronous, any time): same state as clear, plus cdb_rob_id=0, cdb_value=0, cdb_src=0.
  - Outputs after reset: src_full=0, cdb_valid=0, cdb_rob_id=0, cdb_value=0, cdb_src=0.
  - Entries in flight at reset are lost.
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Counts are $clog2(FIFO_DEPTH)+1 bits.

## Timing
- Latency: a push accepted at edge k becomes a request in cycle k+1.
  - If it wins, the broadcast is visible after edge k+1, i.e. 1 cycle after acceptance.
  - Worst-case wait with all sources saturated: NUM_SRC-1 extra cycles per entry ahead of it in round-robin order.
- Once a FIFO is non-empty its head is granted within NUM_SRC cycles, so no source starves.
- src_full depends only on registered state; there is no combinational path from src_valid.
- The cdb_* outputs are registered; there is no combinational path from any input.

## Structure
- Shared defines header: `ROB_WIDTH`, `CDB_SRC_ALU`=0, `CDB_SRC_LSB`=1, `CDB_SRC_NUM`=3.
- Sub-module wb_fifo: a single-clock, synchronous-flush, FIFO_DEPTH-entry FIFO.
  - Ports: push, pop, din, dout (head), empty, full, flush.
  - cdb_arbiter instantiates NUM_SRC copies in a generate loop.
- Round-robin select is combinational logic in cdb_arbiter: a double-width request vector, rotated, with priority encode.

## Test plan
- Reset then single push: rst_in pulse; src_valid=3'b010, rob_id=5, value=0xDEADBEEF at edge k. Then cdb_valid=1, cdb_rob_id=5, cdb_value=0xDEADBEEF, cdb_src=1 after edge k+1; cdb_valid=0 after edge k+2.
- Round-robin fairness: preload every FIFO with 2 entries (ids 0x10+i, 0x20+i); release with no further pushes. The broadcast id sequence is 0x10, 0x11, 0x12, 0x20, 0x21, 0x22, with cdb_valid continuously high for 6 cycles.
- Full/backpressure: hold only src 1 pushing every cycle with the bus granted elsewhere. src_full[1] rises after 4 accepted pushes. A 5th push (id 0x3F) never appears on the bus. Popping one entry drops src_full[1] the following cycle.
- Flush: with entries in all FIFOs and cdb_valid=1, assert clear plus a simultaneous push for 1 cycle. The next cycle has cdb_valid=0 and all src_full=0. The pushed id never appears. Next grant order restarts at src 0.
- Stall: with a pending queue, drop rdy_in for 3 cycles. cdb_* hold their exact values, no entry is lost or duplicated, and pushes during the stall are ignored. The sequence resumes unchanged.
- Asynchronous reset mid-stream: assert rst_in between clock edges while entries are queued. Outputs go to zero immediately. After release, no stale entry is broadcast.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// cdb_arbiter_pkg : shared CDB defines, constants and helpers  | Rev 1.0
// ============================================================================
`ifndef CDB_DEFINES_SVH
`define CDB_DEFINES_SVH
`define ROB_WIDTH   6
`define CDB_SRC_ALU 0
`define CDB_SRC_LSB 1
`define CDB_SRC_NUM 3
`endif

package cdb_arbiter_pkg;
  localparam int CDB_ROB_WIDTH = `ROB_WIDTH;
  localparam int CDB_VALUE_W   = 32;
  localparam int CDB_NUM_SRC   = `CDB_SRC_NUM;
  localparam int CDB_SRC_ALU_IDX = `CDB_SRC_ALU;
  localparam int CDB_SRC_LSB_IDX = `CDB_SRC_LSB;

  // Select width that stays legal for a single-source build.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_wb_fifo.sv
`default_nettype none
// ============================================================================
// wb_fifo : single-clock writeback FIFO with synchronous flush | Rev 1.0
// ============================================================================
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 38
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Full comes from the registered count, so a same-cycle pop never admits a push.
  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign dout      = r_mem[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wptr] <= din;
  end
endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// cdb_arbiter : round-robin common-data-bus arbiter over per-source FIFOs | Rev 1.0
// ============================================================================
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = CDB_NUM_SRC,
  parameter int FIFO_DEPTH = 4,
  parameter int ROB_W      = CDB_ROB_WIDTH
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       clear,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*ROB_W-1:0]   src_rob_id,
  input  logic [NUM_SRC*32-1:0]      src_value,
  output logic [NUM_SRC-1:0]         src_full,
  output logic                       cdb_valid,
  output logic [ROB_W-1:0]           cdb_rob_id,
  output logic [31:0]                cdb_value,
  output logic [sel_w(NUM_SRC)-1:0]  cdb_src
);
  localparam int SW = sel_w(NUM_SRC);
  localparam int EW = ROB_W + CDB_VALUE_W;

  logic [NUM_SRC-1:0] w_empty;
  logic [NUM_SRC-1:0] w_full;
  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_pop;
  logic [NUM_SRC-1:0] w_req;
  logic [NUM_SRC-1:0] w_rot;
  logic [EW-1:0]      w_head [NUM_SRC];
  logic [EW-1:0]      w_gnt_ent;
  logic [SW-1:0]      w_start;
  logic [SW-1:0]      w_off;
  logic [SW:0]        w_sum;
  logic [SW-1:0]      w_gnt;
  logic               w_any;
  logic               w_flush;

  logic               r_cdb_valid;
  logic [ROB_W-1:0]   r_cdb_rob_id;
  logic [31:0]        r_cdb_value;
  logic [SW-1:0]      r_cdb_src;
  logic [SW-1:0]      r_last_g;

  assign w_flush = rdy_in & clear;
  assign w_req   = ~w_empty;

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      assign w_push[i] = rdy_in & ~clear & src_valid[i];
      assign w_pop[i]  = rdy_in & ~clear & w_any & (w_gnt == SW'(i));

      wb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .flush (w_flush),
        .push  (w_push[i]),
        .pop   (w_pop[i]),
        .din   ({src_rob_id[i*ROB_W +: ROB_W], src_value[i*32 +: 32]}),
        .dout  (w_head[i]),
        .empty (w_empty[i]),
        .full  (w_full[i])
      );
    end
  endgenerate

  // Rotate the doubled request vector so bit 0 is the highest-priority source.
  always_comb begin
    w_start   = (r_last_g == SW'(NUM_SRC - 1)) ? '0 : r_last_g + SW'(1);
    w_rot     = NUM_SRC'({w_req, w_req} >> w_start);
    w_any     = 1'b0;
    w_off     = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_any = 1'b1;
        w_off = SW'(k);
      end
    end
    w_sum = {1'b0, w_start} + {1'b0, w_off};
    if (w_sum >= (SW+1)'(NUM_SRC)) w_sum = w_sum - (SW+1)'(NUM_SRC);
    w_gnt     = w_sum[SW-1:0];
    w_gnt_ent = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_gnt == SW'(i)) w_gnt_ent = w_head[i];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cdb_valid  <= 1'b0;
      r_cdb_rob_id <= '0;
      r_cdb_value  <= '0;
      r_cdb_src    <= '0;
      r_last_g     <= SW'(NUM_SRC - 1);
    end else if (rdy_in) begin
      if (clear) begin
        r_cdb_valid <= 1'b0;
        r_last_g    <= SW'(NUM_SRC - 1);
      end else if (w_any) begin
        r_cdb_valid  <= 1'b1;
        r_cdb_rob_id <= w_gnt_ent[EW-1 -: ROB_W];
        r_cdb_value  <= w_gnt_ent[CDB_VALUE_W-1:0];
        r_cdb_src    <= w_gnt;
        r_last_g     <= w_gnt;
      end else begin
        r_cdb_valid <= 1'b0;
      end
    end
  end

  assign src_full   = w_full;
  assign cdb_valid  = r_cdb_valid;
  assign cdb_rob_id = r_cdb_rob_id;
  assign cdb_value  = r_cdb_value;
  assign cdb_src    = r_cdb_src;
endmodule
`default_nettype wire
